// File: rtl/memory_array_rf.sv
// memory_array_rf: DEPTH x WIDTH flip-flop register file, one write port and
// one read port, with a post-reset clear sequencer.
//
// Ports:
//   Clk    - single clock, all state updates on the rising edge
//   Rst_n  - synchronous active-low reset
//   Write  - write enable; Waddr/Data give the target word and value
//   Read   - read enable; Raddr selects the word
//   Q      - registered read data (holds its value when no read is accepted)
//   Qvalid - one-cycle pulse: Q was loaded by a read accepted last edge
//   Ready  - high once the clear sequence is done and accesses are accepted
//
// After reset the array is walked word by word and zeroed (INIT), taking
// exactly DEPTH cycles. Accesses are ignored until Ready rises. Out-of-range
// writes are dropped; out-of-range reads return zero. A read and a write to
// the same in-range word in one cycle return the new data (write-through).
module memory_array_rf #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [WIDTH-1:0]  Data,
  input  logic              Read,
  input  logic [ADDR_W-1:0] Raddr,
  output logic [WIDTH-1:0]  Q,
  output logic              Qvalid,
  output logic              Ready
);

  typedef enum logic {
    INIT,
    IDLE
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] clr_ptr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic waddr_ok;
  logic raddr_ok;
  logic wr_en;
  logic rd_en;
  logic bypass;

  // Next-state and ready decode
  always_comb begin
    state_next = state;
    Ready      = 1'b0;
    case (state)
      INIT: if (clr_ptr == LAST) state_next = IDLE;
      IDLE: Ready = 1'b1;
      default: state_next = INIT;
    endcase
  end

  // Access qualification; all accesses are gated off while clearing
  always_comb begin
    waddr_ok = (Waddr <= LAST);
    raddr_ok = (Raddr <= LAST);
    wr_en    = Ready && Write && waddr_ok;
    rd_en    = Ready && Read;
    // same-address hit implies the read address is in range too
    bypass   = wr_en && (Waddr == Raddr);
  end

  // State register and clear pointer; pointer parks at LAST so it never
  // leaves the valid address range
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= INIT;
      clr_ptr <= '0;
    end else begin
      state <= state_next;
      if (state == INIT && clr_ptr != LAST) clr_ptr <= clr_ptr + ADDR_W'(1);
    end
  end

  // Storage array: no reset of its own, zeroed by the INIT walk instead
  always_ff @(posedge Clk) begin
    if (Rst_n) begin
      if (state == INIT) mem[clr_ptr] <= '0;
      else if (wr_en)    mem[Waddr]   <= Data;
    end
  end

  // Read port
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Q      <= '0;
      Qvalid <= 1'b0;
    end else begin
      Qvalid <= rd_en;
      if (rd_en) begin
        if (!raddr_ok)   Q <= '0;
        else if (bypass) Q <= Data;
        else             Q <= mem[Raddr];
      end
    end
  end

endmodule

// File: tb/tb_memory_array_rf.sv
// Testbench for memory_array_rf: drives one stimulus stream into a default
// (16-word) instance and a 12-word instance, compares both every cycle
// against a behavioural model, and adds directed checks for the key cases.
module tb_memory_array_rf;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr;
  logic       rd;
  logic [3:0] waddr;
  logic [3:0] raddr;
  logic [7:0] data;

  logic [7:0] q16, q12;
  logic       qv16, qv12;
  logic       rdy16, rdy12;

  always #5 clk = ~clk;

  memory_array_rf #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u_dut16 (
    .Clk(clk), .Rst_n(rst_n), .Write(wr), .Waddr(waddr), .Data(data),
    .Read(rd), .Raddr(raddr), .Q(q16), .Qvalid(qv16), .Ready(rdy16)
  );

  memory_array_rf #(.WIDTH(8), .DEPTH(12), .ADDR_W(4)) u_dut12 (
    .Clk(clk), .Rst_n(rst_n), .Write(wr), .Waddr(waddr), .Data(data),
    .Read(rd), .Raddr(raddr), .Q(q12), .Qvalid(qv12), .Ready(rdy12)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Per instance: words still to clear after reset, the word contents, and
  // the read result. Write is applied before the read so a same-address
  // pair naturally returns the new data.
  int unsigned depth_of [2] = '{16, 12};
  logic [7:0]  m_mem  [2][16];
  int unsigned m_left [2];
  logic [7:0]  m_q    [2];
  logic        m_qv   [2];
  bit          m_known = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_left[k] = depth_of[k];
        m_q[k]    = 8'h00;
        m_qv[k]   = 1'b0;
      end else if (m_left[k] != 0) begin
        m_mem[k][depth_of[k] - m_left[k]] = 8'h00;
        m_left[k] = m_left[k] - 1;
        m_qv[k]   = 1'b0;
      end else begin
        if (wr && 32'(waddr) < depth_of[k]) m_mem[k][waddr] = data;
        m_qv[k] = rd;
        if (rd) m_q[k] = (32'(raddr) < depth_of[k]) ? m_mem[k][raddr] : 8'h00;
      end
    end
    if (!rst_n) m_known = 1'b1;
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("q16",    32'(q16),   32'(m_q[0]));
      check("qv16",   32'(qv16),  32'(m_qv[0]));
      check("rdy16",  32'(rdy16), 32'(m_left[0] == 0));
      check("q12",    32'(q12),   32'(m_q[1]));
      check("qv12",   32'(qv12),  32'(m_qv[1]));
      check("rdy12",  32'(rdy12), 32'(m_left[1] == 0));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic r_n, input logic w, input logic [3:0] wa,
                       input logic [7:0] d, input logic r, input logic [3:0] ra);
    @(negedge clk);
    rst_n = r_n; wr = w; waddr = wa; data = d; rd = r; raddr = ra;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
  endtask

  task automatic wr_word(input logic [3:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, d, 1'b0, 4'd0);
  endtask

  task automatic rd_word(input logic [3:0] a);
    drive(1'b1, 1'b0, 4'd0, 8'h00, 1'b1, a);
  endtask

  // Called right after releasing reset; measures cycles until each Ready rises
  task automatic measure_init(input string tag);
    int c16 = -1;
    int c12 = -1;
    for (int i = 0; i < 40; i++) begin
      if (rdy12 && c12 < 0) c12 = i;
      if (rdy16 && c16 < 0) c16 = i;
      if (c16 >= 0) break;
      idle();
    end
    check({tag, "_init16"}, 32'(c16), 32'd16);
    check({tag, "_init12"}, 32'(c12), 32'd12);
  endtask

  task automatic do_reset(input int hold);
    for (int i = 0; i < hold; i++) drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    idle();
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_word(4'(a));
      if (a > 0) begin
        check({tag, "_q"},  32'(q16),  32'h00);
        check({tag, "_qv"}, 32'(qv16), 32'd1);
      end
    end
    idle();
    check({tag, "_q"},  32'(q16),  32'h00);
    check({tag, "_qv"}, 32'(qv16), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0;
    waddr = '0; raddr = '0; data = '0;

    // Reset and INIT timing, then every word reads zero
    do_reset(2);
    check("reset_q",  32'(q16),   32'h00);
    check("reset_qv", 32'(qv16),  32'd0);
    check("reset_rdy",32'(rdy16), 32'd0);
    measure_init("first");
    read_all_zero("clr");

    // Basic write/read
    wr_word(4'd3, 8'hA5);
    wr_word(4'd15, 8'h3C);
    rd_word(4'd3);
    rd_word(4'd15);
    check("rd3",      32'(q16),  32'hA5);
    check("rd3_qv",   32'(qv16), 32'd1);
    idle();
    check("rd15",     32'(q16),  32'h3C);
    check("rd15_qv",  32'(qv16), 32'd1);
    idle();
    check("hold_q",   32'(q16),  32'h3C);
    check("hold_qv",  32'(qv16), 32'd0);

    // Write-through
    wr_word(4'd5, 8'h11);
    drive(1'b1, 1'b1, 4'd5, 8'h22, 1'b1, 4'd5);
    idle();
    check("wt_q",     32'(q16),  32'h22);
    check("wt_qv",    32'(qv16), 32'd1);
    rd_word(4'd5);
    idle();
    check("wt_later", 32'(q16),  32'h22);

    // Out-of-range on the 12-word instance
    wr_word(4'd13, 8'h77);
    rd_word(4'd13);
    rd_word(4'd11);
    check("oor_q12",   32'(q12),  32'h00);
    check("oor_qv12",  32'(qv12), 32'd1);
    check("oor_q16",   32'(q16),  32'h77);
    idle();
    check("w11_q12",   32'(q12),  32'h00);
    check("w11_qv12",  32'(qv12), 32'd1);

    // Accesses during INIT cycle 4 are ignored
    do_reset(2);
    idle();
    idle();
    drive(1'b1, 1'b1, 4'd0, 8'hFF, 1'b1, 4'd0);
    idle();
    check("init_qv16", 32'(qv16), 32'd0);
    check("init_qv12", 32'(qv12), 32'd0);
    for (int i = 0; i < 40 && !rdy16; i++) idle();
    check("init_done", 32'(rdy16), 32'd1);
    rd_word(4'd0);
    idle();
    check("init_w0",   32'(q16),  32'h00);
    check("init_w0qv", 32'(qv16), 32'd1);

    // Fill with non-zero data, then reset in INIT cycle 7
    for (int a = 0; a < 16; a++) wr_word(4'(a), 8'hEE);
    do_reset(1);
    for (int i = 0; i < 5; i++) idle();
    drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 4'd0);
    idle();
    measure_init("mid");
    read_all_zero("mid");

    // Randomised traffic with occasional resets; the model checks every cycle
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 8'($urandom),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
